// File: rtl/jtvigil_objdma.sv
// Object table buffer: CPU-side object RAM plus a shadow copy for the
// sprite scanner, refreshed byte by byte during vertical blank.
module jtvigil_objdma #(
  parameter int AW       = 8,
  parameter int CPU_RDLY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          objram_cs,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    obj_dout,
  input  logic          obj_copy,
  input  logic          LVBL,
  input  logic [AW-1:0] tbl_addr,
  output logic [7:0]    tbl_dout,
  output logic          busy,
  output logic          done
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COPY,
    FLUSH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0] cpu_mem [DEPTH];
  logic [7:0] shadow  [DEPTH];

  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_nxt;
  logic          cnt_clr;

  logic          copy_prev;
  logic          req_edge;
  logic          pending;
  logic          pend_clr;

  logic          cp_we;
  logic [AW-1:0] cp_addr;
  logic [7:0]    cp_data;

  logic          cpu_wr;
  logic          cpu_rd;

  assign cpu_wr   = objram_cs & ~cpu_rnw;
  assign cpu_rd   = objram_cs &  cpu_rnw;
  assign req_edge = obj_copy & ~copy_prev;
  assign cnt_nxt  = cnt_q + 1'b1;

  assign busy = (state_q != IDLE) | pending;
  assign done = (state_q == FLUSH);

  // CPU-side RAM write port; never stalled by a copy
  always_ff @(posedge clk) begin
    if (cpu_wr) begin
      cpu_mem[cpu_addr] <= cpu_dout;
    end
  end

  // Shadow RAM write port, fed only by the copy pipeline
  always_ff @(posedge clk) begin
    if (cp_we) begin
      shadow[cp_addr] <= cp_data;
    end
  end

  // CPU read path with selectable latency; output holds between reads
  generate
    if (CPU_RDLY == 2) begin : g_rd2
      logic       rd_v;
      logic [7:0] rd_d;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_v     <= 1'b0;
          rd_d     <= 8'h00;
          obj_dout <= 8'h00;
        end else begin
          rd_v <= cpu_rd;
          if (cpu_rd) begin
            rd_d <= cpu_mem[cpu_addr];
          end
          if (rd_v) begin
            obj_dout <= rd_d;
          end
        end
      end
    end else begin : g_rd1
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          obj_dout <= 8'h00;
        end else if (cpu_rd) begin
          obj_dout <= cpu_mem[cpu_addr];
        end
      end
    end
  endgenerate

  // Scanner read port: registered, always available
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_dout <= 8'h00;
    end else begin
      tbl_dout <= shadow[tbl_addr];
    end
  end

  // Copy request edge detect; prev resets high so a held level is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      copy_prev <= 1'b1;
      pending   <= 1'b0;
    end else begin
      copy_prev <= obj_copy;
      pending   <= (pending & ~pend_clr) | req_edge;
    end
  end

  // Copy address counter; one extra bit marks the end of the table
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (state_q == COPY) begin
      cnt_q <= cnt_nxt;
    end
  end

  // One-stage copy pipeline: read CPU RAM now, write shadow next clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cp_we   <= 1'b0;
      cp_addr <= '0;
      cp_data <= 8'h00;
    end else begin
      cp_we <= (state_q == COPY);
      if (state_q == COPY) begin
        cp_addr <= cnt_q[AW-1:0];
        cp_data <= cpu_mem[cnt_q[AW-1:0]];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a started copy always runs to completion
  always_comb begin
    state_d  = state_q;
    pend_clr = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!LVBL) begin
          state_d  = COPY;
          pend_clr = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      COPY: begin
        if (cnt_nxt[AW]) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
